// File: rtl/heater_pwm_multi.sv
// Multi-channel heater PWM driver: one shared period counter, phase-staggered channels,
// per-channel enable, duty ceiling and optional soft-start ramp toward the requested on-time.
module heater_pwm_multi #(
    parameter int N_CH      = 2,
    parameter int CNT_W     = 16,
    parameter int PERIOD    = 1011,
    parameter int MAX_DUTY  = 1011,
    parameter int RAMP_STEP = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_CH-1:0]         heater_open,
    input  logic [N_CH*CNT_W-1:0]   high_len,
    output logic [N_CH-1:0]         heater_con,
    output logic [N_CH-1:0]         duty_sat,
    output logic                    period_tick
);
    // One extra bit of headroom so duty + RAMP_STEP and cnt + offset never wrap.
    localparam int AW = CNT_W + 1;
    localparam int STAGGER = PERIOD / N_CH;
    localparam logic [AW-1:0] PERIOD_A = AW'(PERIOD);
    localparam logic [AW-1:0] MAX_A    = AW'(MAX_DUTY);
    localparam logic [AW-1:0] RAMP_A   = AW'(RAMP_STEP);

    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;
    logic          r_tick;

    always_comb begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == PERIOD_A - 1'b1) begin
            w_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_tick <= (r_cnt == '0);
        end
    end

    assign period_tick = r_tick;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            localparam logic [AW-1:0] OFFSET = AW'(gi * STAGGER);

            logic [CNT_W-1:0] w_req;
            logic [AW-1:0]    w_sum;
            logic [AW-1:0]    w_phase;
            logic [AW-1:0]    w_target;
            logic [AW-1:0]    w_ramped;
            logic [AW-1:0]    w_duty_next;
            logic             w_sat;
            logic             w_boundary;

            logic             r_active;
            logic [AW-1:0]    r_duty;
            logic             r_con;
            logic             r_sat;

            always_comb begin
                w_req       = high_len[gi*CNT_W +: CNT_W];
                w_sum       = r_cnt + OFFSET;
                w_phase     = w_sum;
                if (w_sum >= PERIOD_A) begin
                    w_phase = w_sum - PERIOD_A;
                end
                w_boundary  = (w_phase == '0);

                // Request is signed: negative clamps to 0, oversize clamps to the ceiling.
                w_target    = {1'b0, w_req};
                w_sat       = 1'b0;
                if (w_req[CNT_W-1]) begin
                    w_target = '0;
                    w_sat    = 1'b1;
                end else if ({1'b0, w_req} > MAX_A) begin
                    w_target = MAX_A;
                    w_sat    = 1'b1;
                end

                w_ramped    = r_duty + RAMP_A;
                w_duty_next = w_target;
                if (RAMP_STEP != 0 && w_target > r_duty && w_ramped < w_target) begin
                    w_duty_next = w_ramped;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_active <= 1'b0;
                    r_duty   <= '0;
                    r_con    <= 1'b0;
                    r_sat    <= 1'b0;
                end else if (!heater_open[gi]) begin
                    r_active <= 1'b0;
                    r_duty   <= '0;
                    r_con    <= 1'b0;
                    if (w_boundary) begin
                        r_sat <= w_sat;
                    end
                end else if (w_boundary) begin
                    r_active <= 1'b1;
                    r_duty   <= w_duty_next;
                    r_con    <= (w_duty_next != '0);
                    r_sat    <= w_sat;
                end else begin
                    r_con    <= r_active && (w_phase < r_duty);
                end
            end

            assign heater_con[gi] = r_con;
            assign duty_sat[gi]   = r_sat;
        end
    endgenerate

endmodule
